// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction-fetch stage with variable-latency imem port, skid buffer and IF/ID register
//
// Owns the fetch PC, issues requests to instruction memory, buffers one word
// across decode stalls, drops the stale response after a redirect and fills
// the IF/ID pipeline register.
//
// Optional build macro: FETCH_PERF_CNT_EN adds saturating performance counters.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   stall_F                     hold IF/ID and PC
//   redirect_D, redirect_pc_D   taken branch from decode and its target
//   imem_req, imem_addr         request valid and address (always pc)
//   imem_rdy, imem_data         response valid and word
//   pc                          current fetch PC
//   instruction                 word accepted this cycle, NOP_INSTR otherwise
//   instr_D, pc_plus2_D, valid_D  IF/ID register
//   halt_fetched                HLT delivered, fetch frozen
//   stall_cycles, flush_count, imem_wait_cycles  (FETCH_PERF_CNT_EN only)

module fetch_stage #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [15:0] NOP_INSTR   = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_F,
    input  logic        redirect_D,
    input  logic [15:0] redirect_pc_D,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    output logic [15:0] pc,
    output logic [15:0] instruction,
    output logic [15:0] instr_D,
    output logic [15:0] pc_plus2_D,
    output logic        valid_D,
    output logic        halt_fetched
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count,
    output logic [31:0] imem_wait_cycles
`endif
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DRAIN  = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } fetchState_t;

    fetchState_t state, stateNext;

    logic [15:0] skidWord, skidNext;
    logic [15:0] pcNext, instrNext, pcPlus2Next;
    logic        validNext, haltNext;
    logic [15:0] pcPlus2;
    logic        accept;
    logic        deliverNow;
    logic [15:0] deliverWord;

    assign pcPlus2 = pc + 16'd2;
    assign accept  = (state == FETCH) && imem_rdy;

    // Request is suppressed during the reset cycle so nothing is issued
    // against a PC that is about to be overwritten.
    assign imem_req    = rst_n && (state == FETCH);
    assign imem_addr   = pc;
    assign instruction = accept ? imem_data : NOP_INSTR;

    always_comb begin
        stateNext   = state;
        pcNext      = pc;
        skidNext    = skidWord;
        instrNext   = instr_D;
        pcPlus2Next = pc_plus2_D;
        validNext   = valid_D;
        haltNext    = halt_fetched;
        deliverNow  = 1'b0;
        deliverWord = NOP_INSTR;

        if (redirect_D) begin
            pcNext    = redirect_pc_D & 16'hFFFE;
            instrNext = NOP_INSTR;
            validNext = 1'b0;
            skidNext  = NOP_INSTR;
            haltNext  = 1'b0;
            // A request still in flight will answer later; that answer
            // belongs to the old path and must be swallowed in DRAIN.
            stateNext = (state == FETCH && !imem_rdy) ? DRAIN : FETCH;
        end else if (stall_F) begin
            if (accept) begin
                skidNext  = imem_data;
                stateNext = HOLD;
            end else if (state == DRAIN && imem_rdy) begin
                stateNext = FETCH;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (imem_rdy) begin
                        deliverNow  = 1'b1;
                        deliverWord = imem_data;
                    end
                end
                HOLD: begin
                    deliverNow  = 1'b1;
                    deliverWord = skidWord;
                end
                DRAIN: begin
                    if (imem_rdy) begin
                        stateNext = FETCH;
                    end
                end
                default: begin
                end
            endcase

            if (deliverNow) begin
                instrNext   = deliverWord;
                pcPlus2Next = pcPlus2;
                validNext   = 1'b1;
                // HLT parks the PC on its own address so a trace shows
                // where the program stopped.
                if (deliverWord[15:12] == HALT_OPCODE) begin
                    haltNext  = 1'b1;
                    stateNext = HALTED;
                end else begin
                    pcNext    = pcPlus2;
                    stateNext = FETCH;
                end
            end else begin
                instrNext = NOP_INSTR;
                validNext = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            skidWord     <= NOP_INSTR;
            instr_D      <= NOP_INSTR;
            pc_plus2_D   <= 16'h0000;
            valid_D      <= 1'b0;
            halt_fetched <= 1'b0;
        end else begin
            state        <= stateNext;
            pc           <= pcNext;
            skidWord     <= skidNext;
            instr_D      <= instrNext;
            pc_plus2_D   <= pcPlus2Next;
            valid_D      <= validNext;
            halt_fetched <= haltNext;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles     <= 32'd0;
            flush_count      <= 32'd0;
            imem_wait_cycles <= 32'd0;
        end else begin
            if (stall_F && stall_cycles != 32'hFFFF_FFFF) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (redirect_D && flush_count != 32'hFFFF_FFFF) begin
                flush_count <= flush_count + 32'd1;
            end
            if (state == FETCH && !imem_rdy && imem_wait_cycles != 32'hFFFF_FFFF) begin
                imem_wait_cycles <= imem_wait_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage: directed vector table plus randomized run against a reference model

module tb_fetch_stage;

    localparam logic [15:0] RESET_PC    = 16'h0000;
    localparam logic [15:0] NOP_INSTR   = 16'h0000;
    localparam logic [3:0]  HALT_OPCODE = 4'hF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_F = 1'b0;
    logic        redirect_D = 1'b0;
    logic [15:0] redirect_pc_D = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy = 1'b0;
    logic [15:0] imem_data = 16'h0000;
    logic [15:0] pc;
    logic [15:0] instruction;
    logic [15:0] instr_D;
    logic [15:0] pc_plus2_D;
    logic        valid_D;
    logic        halt_fetched;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_count, imem_wait_cycles;
`endif

    fetch_stage #(
        .RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR), .HALT_OPCODE(HALT_OPCODE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall_F(stall_F), .redirect_D(redirect_D),
        .redirect_pc_D(redirect_pc_D), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdy(imem_rdy), .imem_data(imem_data), .pc(pc), .instruction(instruction),
        .instr_D(instr_D), .pc_plus2_D(pc_plus2_D), .valid_D(valid_D),
        .halt_fetched(halt_fetched)
`ifdef FETCH_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count),
        .imem_wait_cycles(imem_wait_cycles)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the fetch unit seen as "pc, a queue of at most one
    // parked word, a pending stale response, and a halted flag".
    logic [15:0] mPc = RESET_PC, mInstr = NOP_INSTR, mPc2 = 16'h0000;
    bit          mValid = 0, mHalt = 0, mStale = 0;
    logic [15:0] mParked[$];
    logic [31:0] mStallCnt = 0, mFlushCnt = 0, mWaitCnt = 0;

    function automatic bit mRequesting();
        return !mStale && mParked.size() == 0 && !mHalt;
    endfunction

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic modelEdge(input bit rstn, stall, redir, input logic [15:0] rpc,
                             input bit rdy, input logic [15:0] data);
        bit          req;
        bit          have;
        logic [15:0] w;
        req  = mRequesting();
        have = 0;
        w    = NOP_INSTR;
        if (!rstn) begin
            mPc = RESET_PC; mInstr = NOP_INSTR; mPc2 = 16'h0000;
            mValid = 0; mHalt = 0; mStale = 0; mParked.delete();
            mStallCnt = 0; mFlushCnt = 0; mWaitCnt = 0;
            return;
        end
        if (stall) mStallCnt = sat(mStallCnt);
        if (redir) mFlushCnt = sat(mFlushCnt);
        if (req && !rdy) mWaitCnt = sat(mWaitCnt);
        if (redir) begin
            mStale  = req && !rdy;
            mPc     = rpc & 16'hFFFE;
            mInstr  = NOP_INSTR;
            mValid  = 0;
            mHalt   = 0;
            mParked.delete();
            return;
        end
        if (mParked.size() != 0) begin
            have = 1; w = mParked[0];
        end else if (req && rdy) begin
            have = 1; w = data;
        end
        if (mStale && rdy) mStale = 0;
        if (stall) begin
            if (have && mParked.size() == 0) mParked.push_back(w);
        end else if (have) begin
            mParked.delete();
            mInstr = w;
            mPc2   = mPc + 16'd2;
            mValid = 1;
            if (w[15:12] == HALT_OPCODE) mHalt = 1;
            else mPc = mPc + 16'd2;
        end else begin
            mInstr = NOP_INSTR;
            mValid = 0;
        end
    endtask

    // One clock: drive at negedge, check combinational outputs, take the
    // edge, update the model and check the registered outputs.
    task automatic step(input bit rstn, stall, redir, input logic [15:0] rpc,
                        input bit rdy, input logic [15:0] data,
                        output bit reqSeen, output logic [15:0] addrSeen);
        @(negedge clk);
        rst_n = rstn; stall_F = stall; redirect_D = redir;
        redirect_pc_D = rpc; imem_rdy = rdy; imem_data = data;
        #1;
        reqSeen  = imem_req;
        addrSeen = imem_addr;
        chk("imem_req", {31'd0, imem_req}, {31'd0, rstn && mRequesting()});
        if (rstn) begin
            chk("imem_addr", {16'd0, imem_addr}, {16'd0, mPc});
            chk("instruction", {16'd0, instruction},
                {16'd0, (mRequesting() && rdy) ? data : NOP_INSTR});
        end
        @(posedge clk);
        modelEdge(rstn, stall, redir, rpc, rdy, data);
        #1;
        chk("pc", {16'd0, pc}, {16'd0, mPc});
        chk("instr_D", {16'd0, instr_D}, {16'd0, mInstr});
        chk("pc_plus2_D", {16'd0, pc_plus2_D}, {16'd0, mPc2});
        chk("valid_D", {31'd0, valid_D}, {31'd0, mValid});
        chk("halt_fetched", {31'd0, halt_fetched}, {31'd0, mHalt});
`ifdef FETCH_PERF_CNT_EN
        chk("stall_cycles", stall_cycles, mStallCnt);
        chk("flush_count", flush_count, mFlushCnt);
        chk("imem_wait_cycles", imem_wait_cycles, mWaitCnt);
`endif
    endtask

    typedef struct {
        bit          rstn, stall, redir;
        logic [15:0] rpc;
        bit          rdy;
        logic [15:0] data;
        bit          eReq;
        logic [15:0] eAddr, ePc, eInstr, ePc2;
        bit          eValid, eHalt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rstn, bit stall, bit redir, logic [15:0] rpc, bit rdy,
                                logic [15:0] data, bit eReq, logic [15:0] eAddr,
                                logic [15:0] ePc, logic [15:0] eInstr, logic [15:0] ePc2,
                                bit eValid, bit eHalt);
        vec_t v;
        v.rstn = rstn; v.stall = stall; v.redir = redir; v.rpc = rpc; v.rdy = rdy;
        v.data = data; v.eReq = eReq; v.eAddr = eAddr; v.ePc = ePc; v.eInstr = eInstr;
        v.ePc2 = ePc2; v.eValid = eValid; v.eHalt = eHalt;
        return v;
    endfunction

    initial begin
        bit          rq;
        logic [15:0] ad;

        //               rst st rd rpc       rdy data      req addr      pc        instr     pc2       v  h
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0));
        // zero-wait sequential
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'h1123, 1, 16'h0000, 16'h0002, 16'h1123, 16'h0002, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'h2234, 1, 16'h0002, 16'h0004, 16'h2234, 16'h0004, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'h3345, 1, 16'h0004, 16'h0006, 16'h3345, 16'h0006, 1, 0));
        // latency 3
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'h4456, 1, 16'h0000, 16'h0002, 16'h4456, 16'h0002, 1, 0));
        // stall on arrival, two stalled cycles then release
        vecs.push_back(mk(1, 1, 0, 16'h0000, 1, 16'hA5A5, 1, 16'h0002, 16'h0002, 16'h4456, 16'h0002, 1, 0));
        vecs.push_back(mk(1, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0002, 16'h0002, 16'h4456, 16'h0002, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0002, 16'h0004, 16'hA5A5, 16'h0004, 1, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0004, 16'h0004, 16'h0000, 16'h0004, 0, 0));
        // redirect while a request is outstanding
        vecs.push_back(mk(1, 0, 1, 16'h0010, 1, 16'h7777, 1, 16'h0004, 16'h0010, 16'h0000, 16'h0004, 0, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0010, 16'h0010, 16'h0000, 16'h0004, 0, 0));
        vecs.push_back(mk(1, 0, 1, 16'h0041, 0, 16'h0000, 1, 16'h0010, 16'h0040, 16'h0000, 16'h0004, 0, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0040, 16'h0040, 16'h0000, 16'h0004, 0, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'h9999, 0, 16'h0040, 16'h0040, 16'h0000, 16'h0004, 0, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'h1357, 1, 16'h0040, 16'h0042, 16'h1357, 16'h0042, 1, 0));
        // HLT at 0x0008, then resume by redirect
        vecs.push_back(mk(1, 0, 1, 16'h0008, 1, 16'h0000, 1, 16'h0042, 16'h0008, 16'h0000, 16'h0042, 0, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'hF000, 1, 16'h0008, 16'h0008, 16'hF000, 16'h000A, 1, 1));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'h1111, 0, 16'h0008, 16'h0008, 16'h0000, 16'h000A, 0, 1));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0008, 16'h0008, 16'h0000, 16'h000A, 0, 1));
        vecs.push_back(mk(1, 0, 1, 16'h0020, 0, 16'h0000, 0, 16'h0008, 16'h0020, 16'h0000, 16'h000A, 0, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'h2468, 1, 16'h0020, 16'h0022, 16'h2468, 16'h0022, 1, 0));
        // PC wrap
        vecs.push_back(mk(1, 0, 1, 16'hFFFE, 1, 16'h0000, 1, 16'h0022, 16'hFFFE, 16'h0000, 16'h0022, 0, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'h5555, 1, 16'hFFFE, 16'h0000, 16'h5555, 16'h0000, 1, 0));
        // reset mid-request with a late response during reset
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h6666, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'h7070, 1, 16'h0000, 16'h0002, 16'h7070, 16'h0002, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rstn, vecs[i].stall, vecs[i].redir, vecs[i].rpc,
                 vecs[i].rdy, vecs[i].data, rq, ad);
            chk($sformatf("vec%0d_req", i), {31'd0, rq}, {31'd0, vecs[i].eReq});
            if (vecs[i].rstn)
                chk($sformatf("vec%0d_addr", i), {16'd0, ad}, {16'd0, vecs[i].eAddr});
            chk($sformatf("vec%0d_pc", i), {16'd0, pc}, {16'd0, vecs[i].ePc});
            chk($sformatf("vec%0d_instr_D", i), {16'd0, instr_D}, {16'd0, vecs[i].eInstr});
            chk($sformatf("vec%0d_pc_plus2_D", i), {16'd0, pc_plus2_D}, {16'd0, vecs[i].ePc2});
            chk($sformatf("vec%0d_valid_D", i), {31'd0, valid_D}, {31'd0, vecs[i].eValid});
            chk($sformatf("vec%0d_halt", i), {31'd0, halt_fetched}, {31'd0, vecs[i].eHalt});
        end

        // Redirect while a word is parked: the parked word must be lost.
        step(0, 0, 0, 16'h0000, 0, 16'h0000, rq, ad);
        step(1, 1, 0, 16'h0000, 1, 16'hABCD, rq, ad);
        chk("hold_req_low", {31'd0, imem_req}, 32'd0);
        step(1, 0, 1, 16'h0030, 0, 16'h0000, rq, ad);
        chk("hold_redir_pc", {16'd0, pc}, 32'h0030);
        step(1, 0, 0, 16'h0000, 0, 16'h0000, rq, ad);
        chk("hold_redir_req", {31'd0, rq}, 32'd1);
        chk("hold_redir_valid", {31'd0, valid_D}, 32'd0);
        chk("hold_redir_instr", {16'd0, instr_D}, {16'd0, NOP_INSTR});

        // Redirect while draining: next fetch at the newest target.
        step(1, 0, 1, 16'h0100, 0, 16'h0000, rq, ad);
        step(1, 0, 1, 16'h0200, 0, 16'h0000, rq, ad);
        step(1, 0, 0, 16'h0000, 1, 16'h0202, rq, ad);
        chk("drain_redir_addr", {16'd0, ad}, 32'h0200);
        chk("drain_redir_pc", {16'd0, pc}, 32'h0202);

        // Randomized run against the model.
        for (int n = 0; n < 3000; n++) begin
            bit          rstn, stall, redir, rdy;
            logic [15:0] rpc, data;
            rstn  = ($urandom_range(0, 99) != 0);
            stall = ($urandom_range(0, 3) == 0);
            redir = ($urandom_range(0, 11) == 0);
            rdy   = 1'($urandom_range(0, 1));
            rpc   = 16'($urandom);
            data  = 16'($urandom);
            if ($urandom_range(0, 19) == 0) data[15:12] = HALT_OPCODE;
            else data[15:12] = 4'($urandom_range(0, 14));
            step(rstn, stall, redir, rpc, rdy, data, rq, ad);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
